// File: rtl/sd_write_sector.sv
// rtl/sd_write_sector.sv - SPI-mode CMD24 single-block writer with R1/data-response checks and busy wait
// Defining SD_WR_TIMEOUT_EN adds the R1 and response/busy timeouts.
module sd_write_sector #(
  parameter int WORDS        = 256,
  parameter int R1_TIMEOUT   = 64,
  parameter int BUSY_TIMEOUT = 2_500_000
) (
  input  logic        clk_ref,
  input  logic        sys_rst,
  input  logic        sd_init_done,
  input  logic        wr_start_en,
  input  logic [31:0] wr_sec_addr,
  input  logic [15:0] wr_data,
  output logic        wr_req,
  output logic        wr_busy,
  output logic        wr_done,
  output logic        wr_err,
  input  logic        sd_miso,
  output logic        sd_cs,
  output logic        sd_mosi
);

  localparam int DBITS = WORDS * 16;
  localparam int CW    = (DBITS > 64) ? $clog2(DBITS) : 6;

  typedef enum logic [3:0] {
    IDLE, CMD, WAIT_R1, GAP, TOKEN, DATA, CRC, WAIT_RESP, BUSY, TAIL, DONE, ERR
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [47:0]   sh, sh_n;
  logic [6:0]    cap, cap_n;
  logic          capt, capt_n;
  logic [7:0]    r1_val;
  logic [4:0]    resp_val;

  // The bit sampled this cycle completes the R1 / data-response token.
  assign r1_val   = {cap, sd_miso};
  assign resp_val = {cap[3:0], sd_miso};

`ifdef SD_WR_TIMEOUT_EN
  localparam int TMAX = (BUSY_TIMEOUT > R1_TIMEOUT) ? BUSY_TIMEOUT : R1_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);
  logic [TW-1:0] tmo, tmo_n;
`else
  logic [31:0] unused_tmo;
  assign unused_tmo = 32'(R1_TIMEOUT ^ BUSY_TIMEOUT);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    cap_n   = cap;
    capt_n  = capt;
    unique case (state)
      IDLE: begin
        if (wr_start_en && sd_init_done) begin
          state_n = CMD;
          cnt_n   = '0;
          sh_n    = {8'h58, wr_sec_addr, 8'hFF};
        end
      end
      CMD: begin
        sh_n  = {sh[46:0], 1'b1};
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(47)) begin
          state_n = WAIT_R1;
          cnt_n   = '0;
          capt_n  = 1'b0;
        end
      end
      WAIT_R1: begin
        if (capt) begin
          cap_n = {cap[5:0], sd_miso};
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(7)) begin
            cnt_n   = '0;
            capt_n  = 1'b0;
            state_n = (r1_val == 8'h00) ? GAP : ERR;
          end
        end else if (!sd_miso) begin
          cap_n  = {cap[5:0], 1'b0};
          capt_n = 1'b1;
          cnt_n  = CW'(1);
        end
      end
      GAP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(7)) begin
          state_n = TOKEN;
          cnt_n   = '0;
          sh_n    = {8'hFE, 40'hFF_FFFF_FFFF};
        end
      end
      TOKEN: begin
        sh_n  = {sh[46:0], 1'b1};
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(7)) begin
          state_n = DATA;
          cnt_n   = '0;
          sh_n    = {wr_data, 32'hFFFF_FFFF};
        end
      end
      DATA: begin
        // Next word is loaded as bit 0 of the current one leaves, so bits never gap.
        sh_n  = {sh[46:0], 1'b1};
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(DBITS - 1)) begin
          state_n = CRC;
          cnt_n   = '0;
        end else if (cnt[3:0] == 4'hF) begin
          sh_n = {wr_data, 32'hFFFF_FFFF};
        end
      end
      CRC: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(15)) begin
          state_n = WAIT_RESP;
          cnt_n   = '0;
          capt_n  = 1'b0;
        end
      end
      WAIT_RESP: begin
        if (capt) begin
          cap_n = {cap[5:0], sd_miso};
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(4)) begin
            cnt_n   = '0;
            capt_n  = 1'b0;
            state_n = (resp_val == 5'b00101) ? BUSY : ERR;
          end
        end else if (!sd_miso) begin
          cap_n  = {cap[5:0], 1'b0};
          capt_n = 1'b1;
          cnt_n  = CW'(1);
        end
      end
      BUSY: begin
        if (sd_miso) begin
          state_n = TAIL;
          cnt_n   = '0;
        end
      end
      TAIL: begin
        cnt_n = cnt + 1'b1;
        if (cnt == CW'(7)) begin
          state_n = DONE;
          cnt_n   = '0;
        end
      end
      DONE, ERR: begin
        state_n = IDLE;
        cnt_n   = '0;
        capt_n  = 1'b0;
        sh_n    = '1;
      end
      default: state_n = IDLE;
    endcase

`ifdef SD_WR_TIMEOUT_EN
    // One counter covers both response and busy so the limit spans the whole wait.
    tmo_n = '0;
    if ((state == WAIT_R1 && !capt) || state == WAIT_RESP || state == BUSY)
      tmo_n = tmo + 1'b1;
    if (state_n == WAIT_R1 && !capt_n && tmo >= TW'(R1_TIMEOUT - 1))
      state_n = ERR;
    if ((state_n == WAIT_RESP || state_n == BUSY) && tmo >= TW'(BUSY_TIMEOUT - 1))
      state_n = ERR;
`endif
  end

  always_ff @(posedge clk_ref) begin
    if (sys_rst) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '1;
      cap   <= '0;
      capt  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      sh    <= sh_n;
      cap   <= cap_n;
      capt  <= capt_n;
    end
  end

`ifdef SD_WR_TIMEOUT_EN
  always_ff @(posedge clk_ref) begin
    if (sys_rst) tmo <= '0;
    else         tmo <= tmo_n;
  end
`endif

  assign sd_mosi = sh[47];
  assign wr_busy = !(state inside {IDLE, DONE, ERR});
  assign sd_cs   = !wr_busy;
  assign wr_done = (state == DONE);
  assign wr_err  = (state == ERR);
  assign wr_req  = (state == TOKEN && cnt == CW'(6)) ||
                   (state == DATA && cnt[3:0] == 4'hE && cnt < CW'(DBITS - 16));

endmodule

// File: tb/tb_sd_write_sector.sv
// tb/tb_sd_write_sector.sv - self-checking bench for sd_write_sector
// Expected per-cycle output traces are built from the protocol timeline.
module tb_sd_write_sector;

  localparam int WORDS = 256;
  localparam int MAXC  = 6000;

  logic        clk_ref = 1'b0;
  logic        sys_rst = 1'b1;
  logic        sd_init_done = 1'b0;
  logic        wr_start_en = 1'b0;
  logic [31:0] wr_sec_addr = 32'h0;
  logic [15:0] wr_data = 16'h0;
  logic        sd_miso = 1'b1;
  logic        wr_req, wr_busy, wr_done, wr_err, sd_cs, sd_mosi;

  int checks = 0;
  int failures = 0;

  always #5 clk_ref = ~clk_ref;

  sd_write_sector #(.WORDS(WORDS), .R1_TIMEOUT(64), .BUSY_TIMEOUT(1000)) dut (
    .clk_ref(clk_ref), .sys_rst(sys_rst), .sd_init_done(sd_init_done),
    .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .wr_data(wr_data),
    .wr_req(wr_req), .wr_busy(wr_busy), .wr_done(wr_done), .wr_err(wr_err),
    .sd_miso(sd_miso), .sd_cs(sd_cs), .sd_mosi(sd_mosi)
  );

  // {cs, mosi, busy, req, done, err} expected for each cycle after the start cycle
  logic [5:0]  exp_o [MAXC];
  logic        exp_miso [MAXC];
  logic [15:0] mem [WORDS];
  logic [31:0] cur_addr;
  int          tok_c, data_c;
  int          n_req, n_done, n_err;
  logic [47:0] cmd_seen;
  logic [7:0]  tok_seen;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  function automatic void put(input int c, input logic m);
    exp_o[c] = {1'b0, m, 1'b1, 3'b000};
  endfunction

  task automatic build(input logic [31:0] addr, input logic [7:0] r1, input int r1d,
                       input logic [4:0] resp, input int rd, input int nb, input int seed,
                       output int last);
    logic [47:0] cmd;
    logic [7:0]  tok;
    int tr, t, d, w, e;
    cur_addr = addr;
    tok_c = -1;
    data_c = -1;
    for (int c = 0; c < MAXC; c++) begin
      exp_o[c] = 6'b110000;
      exp_miso[c] = 1'b1;
    end
    for (int n = 0; n < WORDS; n++) mem[n] = 16'((n * 40503 + seed) ^ (n << 7));
    cmd = {8'h58, addr, 8'hFF};
    for (int i = 0; i < 48; i++) put(1 + i, cmd[47 - i]);
    tr = 49 + r1d;
    for (int c = 49; c < tr + 8; c++) put(c, 1'b1);
    for (int i = 0; i < 8; i++) exp_miso[tr + i] = r1[7 - i];
    if (r1 != 8'h00) begin
      exp_o[tr + 8] = 6'b110001;
      last = tr + 12;
      return;
    end
    for (int c = tr + 8; c < tr + 16; c++) put(c, 1'b1);
    t = tr + 16;
    tok_c = t;
    tok = 8'hFE;
    for (int i = 0; i < 8; i++) put(t + i, tok[7 - i]);
    exp_o[t + 6][2] = 1'b1;
    d = t + 8;
    data_c = d;
    for (int n = 0; n < WORDS; n++) begin
      for (int i = 0; i < 16; i++) put(d + 16 * n + i, mem[n][15 - i]);
      if (n < WORDS - 1) exp_o[d + 16 * n + 14][2] = 1'b1;
    end
    w = d + 16 * WORDS + 16;
    for (int c = d + 16 * WORDS; c < w + rd + 5; c++) put(c, 1'b1);
    for (int i = 0; i < 5; i++) exp_miso[w + rd + i] = resp[4 - i];
    e = w + rd + 5;
    if (resp != 5'b00101) begin
      exp_o[e] = 6'b110001;
      last = e + 4;
      return;
    end
    if (nb < 0) begin
      for (int c = e; c < e + 30; c++) begin
        put(c, 1'b1);
        exp_miso[c] = 1'b0;
      end
      last = e + 29;
      return;
    end
    for (int c = e; c < e + nb; c++) exp_miso[c] = 1'b0;
    for (int c = e; c < e + nb + 9; c++) put(c, 1'b1);
    exp_o[e + nb + 9] = 6'b110010;
    last = e + nb + 12;
  endtask

  task automatic run(input int last, input logic init, input int extra_c, input int rst_c);
    int sfail;
    int ridx;
    logic req_prev;
    logic [5:0] got;
    sfail = 0;
    ridx = 0;
    req_prev = 1'b0;
    n_req = 0; n_done = 0; n_err = 0;
    cmd_seen = '0; tok_seen = '0;
    if (!init)
      for (int c = 0; c <= last; c++) begin
        exp_o[c] = 6'b110000;
        exp_miso[c] = 1'b1;
      end
    if (rst_c >= 0)
      for (int c = rst_c + 1; c <= last; c++) exp_o[c] = 6'b110000;
    sd_init_done = init;
    for (int c = 0; c <= last; c++) begin
      @(posedge clk_ref); #1;
      wr_start_en = (c == 0) || (c == extra_c);
      wr_sec_addr = (c == 0) ? cur_addr : ~cur_addr;
      sys_rst = (c == rst_c);
      sd_miso = exp_miso[c];
      if (req_prev && ridx < WORDS) begin
        wr_data = mem[ridx];
        ridx++;
      end else begin
        wr_data = 16'hDEAD;
      end
      @(negedge clk_ref);
      got = {sd_cs, sd_mosi, wr_busy, wr_req, wr_done, wr_err};
      if (sfail < 8) begin
        checks++;
        if (got !== exp_o[c]) begin
          failures++;
          sfail++;
          $display("FAIL trace c=%0d got=%b want=%b (cs mosi busy req done err)", c, got, exp_o[c]);
        end
      end
      req_prev = wr_req;
      n_req += int'(wr_req);
      n_done += int'(wr_done);
      n_err += int'(wr_err);
      if (c >= 1 && c <= 48) cmd_seen = {cmd_seen[46:0], sd_mosi};
      if (tok_c >= 0 && c >= tok_c && c < tok_c + 8) tok_seen = {tok_seen[6:0], sd_mosi};
    end
    wr_start_en = 1'b0;
    sys_rst = 1'b0;
  endtask

  initial begin
    int last;
    logic found;

    repeat (3) @(posedge clk_ref);
    @(negedge clk_ref);
    check("reset_outputs", {sd_cs, sd_mosi, wr_busy, wr_req, wr_done, wr_err}, 6'b110000);
    @(posedge clk_ref); #1;
    sys_rst = 1'b0;

    // start ignored while card not initialised
    build(32'h0000_1234, 8'h00, 2, 5'b00101, 1, 100, 1, last);
    run(40, 1'b0, -1, -1);
    check("noinit_req", n_req, 0);
    check("noinit_cs", sd_cs, 1);

    // nominal write with a start pulse during the data phase
    build(32'h0000_1234, 8'h00, 2, 5'b00101, 1, 100, 7, last);
    run(last, 1'b1, tok_c + 200, -1);
    check("nom_cmd", cmd_seen, 48'h58_0000_1234_FF);
    check("nom_token", tok_seen, 8'hFE);
    check("nom_req_count", n_req, 256);
    check("nom_done_count", n_done, 1);
    check("nom_err_count", n_err, 0);
    check("nom_cs_end", sd_cs, 1);

    // R1 = 0x04
    build(32'hDEAD_BEEF, 8'h04, 0, 5'b00101, 0, 0, 2, last);
    run(last, 1'b1, -1, -1);
    check("r1_cmd", cmd_seen, 48'h58_DEAD_BEEF_FF);
    check("r1_req_count", n_req, 0);
    check("r1_err_count", n_err, 1);
    check("r1_done_count", n_done, 0);
    check("r1_idle", {sd_cs, wr_busy}, 2'b10);

    // CRC-rejected data response 0x0B
    build(32'h0000_0001, 8'h00, 3, 5'b01011, 2, 100, 3, last);
    run(last, 1'b1, -1, -1);
    check("crc_err_count", n_err, 1);
    check("crc_done_count", n_done, 0);
    check("crc_req_count", n_req, 256);

    // reset during word 100, then a clean transfer
    build(32'h00AB_CDEF, 8'h00, 1, 5'b00101, 0, 20, 11, last);
    run(data_c + 1610, 1'b1, -1, data_c + 1605);
    check("rst_req_count", n_req, 101);
    check("rst_done_err", {n_done, n_err}, 64'h0);
    check("rst_idle", {sd_cs, sd_mosi, wr_busy}, 3'b110);
    build(32'h0000_0200, 8'h00, 0, 5'b00101, 0, 5, 21, last);
    run(last, 1'b1, -1, -1);
    check("post_rst_cmd", cmd_seen, 48'h58_0000_0200_FF);
    check("post_rst_req_count", n_req, 256);
    check("post_rst_done", n_done, 1);

    // card stays busy forever after an accepted response
    build(32'h0000_0007, 8'h00, 1, 5'b00101, 1, -1, 5, last);
    run(last, 1'b1, -1, -1);
`ifdef SD_WR_TIMEOUT_EN
    found = 1'b0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk_ref);
      if (wr_err) found = 1'b1;
    end
    check("busy_timeout_err", found, 1);
`else
    found = 1'b0;
    repeat (5000) begin
      @(negedge clk_ref);
      if (wr_err || wr_done) found = 1'b1;
    end
    check("busy_no_timeout_pulse", found, 0);
    check("busy_still_busy", {wr_busy, sd_cs}, 2'b10);
`endif
    @(posedge clk_ref); #1;
    sys_rst = 1'b1;
    @(posedge clk_ref); #1;
    sys_rst = 1'b0;
    @(negedge clk_ref);
    check("final_reset", {sd_cs, sd_mosi, wr_busy, wr_req, wr_done, wr_err}, 6'b110000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_write_sector.md
# sd_write_sector

SPI-mode single-block writer for the SD card (CMD24): the write-direction counterpart of the sector read path in `sd_ctrl_top`. It takes a start pulse and a 32-bit sector address, pulls 256 16-bit words from a synchronous source (the frame `ram`) through a request/data handshake, and shifts command, token, data and CRC onto `sd_mosi`. It then checks the card's R1 and data-response tokens and waits out card busy. It sits beside the read engine, clocked by `clk_25m`, sharing `sd_cs`/`sd_mosi` through the top-level mux.

## Interface
- `WORDS`, 256: 16-bit words per sector (512 bytes).
- `R1_TIMEOUT`, 64: max `sd_clk` cycles waiting for R1 start bit.
- `BUSY_TIMEOUT`, 2_500_000: max cycles waiting for data response plus busy release (100 ms at 25 MHz).

- `clk_ref` input 1: 25 MHz clock. `sd_clk` is `~clk_ref` at top level.
- `sys_rst` input 1: synchronous, active-high reset.
- `sd_init_done` input 1: card initialised. Starts are ignored while low.
- `wr_start_en` input 1: one-cycle start pulse.
- `wr_sec_addr` input 32: sector address, latched on accepted start.
- `wr_data` input 16: word, sampled the cycle after `wr_req`.
- `wr_req` output 1: one-cycle request for the next word.
- `wr_busy` output 1: transfer in progress.
- `wr_done` output 1: one-cycle pulse, sector accepted by card.
- `wr_err` output 1: one-cycle pulse, R1 ≠ 0x00, rejected data, or timeout.
- `sd_miso` input 1: card data out.
- `sd_cs` output 1: chip select, active low.
- `sd_mosi` output 1: card data in.

## Operation
- Reset values: `sd_cs`=1, `sd_mosi`=1, `wr_busy`=0, `wr_req`=0, `wr_done`=0, `wr_err`=0. State is IDLE and all counters are 0.
- IDLE: on `wr_start_en && sd_init_done`, latch the address and go to CMD. `wr_busy` and `sd_cs`=0 take effect next cycle.
- CMD: shift 48 bits MSB first: 0x58, addr[31:24..7:0], 0xFF.
- WAIT_R1: drive `sd_mosi`=1 and sample `sd_miso`. The first 0 bit is bit 7 of R1. Capture 8 bits.
  - R1 ≠ 0x00 → ERR.
  - R1 = 0x00 → GAP.
- GAP: 8 cycles of `sd_mosi`=1.
- TOKEN: shift 0xFE.
- DATA: shift `WORDS`×16 bits, each word MSB first.
- CRC: shift 16 bits of 1.
- WAIT_RESP: `sd_mosi`=1. The first 0 bit on `sd_miso` starts a 5-bit capture (0sss1).
  - 5'b00101 → BUSY.
  - Anything else → ERR.
- BUSY: wait for `sd_miso`=1, then TAIL.
- TAIL: 8 cycles of `sd_mosi`=1, then raise `sd_cs`, pulse `wr_done`, return to IDLE.
- ERR: raise `sd_cs`, pulse `wr_err`, return to IDLE. `wr_busy` drops on the same cycle as the done/err pulse.
- `wr_start_en` while busy is ignored.
- Exactly `WORDS` `wr_req` pulses are issued per transfer. None are issued on R1 error.

## Timing
- One bit per `clk_ref` cycle. `sd_mosi` updates on the `clk_ref` rising edge, and the card samples on the `sd_clk` rise (`clk_ref` fall). `sd_miso` is sampled on the `clk_ref` rising edge.
- Start pulse at cycle 0 → `sd_cs`=0 and the first CMD bit on `sd_mosi` at cycle 1.
- Word handshake: `wr_req` is high at cycle k, and `wr_data` is sampled at k+1 into the shift register. Bit 15 appears on `sd_mosi` at k+2.
  - First `wr_req` is on the cycle the token's bit 1 is driven.
  - Each later `wr_req` is on the cycle bit 1 of the current word is driven.
  - Result: data bits stream back-to-back with no gaps.
- Word n (0-based) bit 15 is driven 16·n cycles after word 0 bit 15.
- Reset mid-transfer: all outputs return to reset values on the next cycle. No done/err pulse is issued.

## Configuration
- `SD_WR_TIMEOUT_EN` defined:
  - WAIT_R1 exceeding `R1_TIMEOUT` cycles → ERR.
  - WAIT_RESP + BUSY exceeding `BUSY_TIMEOUT` cycles (combined counter) → ERR.
- Undefined: no timeout counters. WAIT_R1, WAIT_RESP and BUSY wait indefinitely; `wr_err` comes only from R1/data-response checks.

## Test plan
- Nominal write: `wr_sec_addr`=0x00001234, card model returns R1=0x00, response 0x05, 100 busy cycles.
  - `sd_mosi` carries 58 00 00 12 34 FF, then FE, then 512 data bytes, then FF FF.
  - Exactly 256 `wr_req` pulses, data matching the source words.
  - `wr_done` pulses once, `sd_cs` ends high.
- R1=0x04: `wr_err` pulses, no FE token, zero `wr_req`, `sd_cs`=1, `wr_busy`=0.
- Data response 0x0B (CRC reject): `wr_err` after the response bits, no BUSY wait, no `wr_done`.
- `wr_start_en` with `sd_init_done`=0, or during busy: no state change, `sd_cs` stays 1 / transfer unaffected.
- `sys_rst` asserted at word 100 of DATA: next cycle `sd_cs`=1, `sd_mosi`=1, `wr_busy`=0. A fresh start then writes cleanly.
- With `SD_WR_TIMEOUT_EN`, `BUSY_TIMEOUT`=1000, `sd_miso` held 0 after response 0x05: `wr_err` within 1000 cycles. Without the macro: still `wr_busy` at 5000 cycles.
